// File: rtl/dmem_pkg.sv
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared defaults and legal parameter ranges for data_mem_pl.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package dmem_pkg;

    localparam int c_default_data_w     = 32;
    localparam int c_default_addr_w     = 16;
    localparam int c_default_depth      = 65536;
    localparam int c_default_rd_lat     = 1;
    localparam int c_default_resp_depth = 4;

    localparam int c_rd_lat_min         = 1;
    localparam int c_rd_lat_max         = 4;
    localparam int c_resp_depth_min     = 2;

endpackage

`default_nettype wire

// File: rtl/resp_fifo.sv
// ============================================================================
//  Module      : resp_fifo
//  Description : Synchronous FIFO with modulo-DEPTH pointers and full/empty.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module resp_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_push   = push && !full;
    assign w_pop    = pop && !empty;
    assign full     = (r_count == CNT_W'(DEPTH));
    assign empty    = (r_count == '0);
    assign pop_data = empty ? '0 : r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= wrap_inc(r_wptr);
            if (w_pop)  r_rptr <= wrap_inc(r_rptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/data_mem_pl.sv
// ============================================================================
//  Module      : data_mem_pl
//  Description : Byte-enabled word memory with pipelined, flow-controlled reads.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module data_mem_pl
    import dmem_pkg::*;
#(
    parameter int DATA_W     = c_default_data_w,
    parameter int ADDR_W     = c_default_addr_w,
    parameter int DEPTH      = c_default_depth,
    parameter int RD_LAT     = c_default_rd_lat,
    parameter int RESP_DEPTH = c_default_resp_depth
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err
);

    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(RESP_DEPTH + 1);
    localparam int PL_W  = DATA_W + 1;

    generate
        if (RD_LAT < c_rd_lat_min || RD_LAT > c_rd_lat_max) begin : g_bad_rd_lat
            $error("data_mem_pl: RD_LAT must be within 1..4");
        end
        if (DATA_W % 8 != 0) begin : g_bad_data_w
            $error("data_mem_pl: DATA_W must be a multiple of 8");
        end
        if (longint'(DEPTH) > (longint'(1) << ADDR_W)) begin : g_bad_depth
            $error("data_mem_pl: DEPTH exceeds 2**ADDR_W");
        end
        if (RESP_DEPTH < c_resp_depth_min) begin : g_bad_resp_depth
            $error("data_mem_pl: RESP_DEPTH must be at least 2");
        end
    endgenerate

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [RD_LAT-1:0] r_pv;
    logic [PL_W-1:0]   r_pd [RD_LAT];
    logic [CNT_W-1:0]  r_outstanding;
    logic              r_live;

    logic              w_in_range;
    logic [IDX_W-1:0]  w_idx;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [DATA_W-1:0] w_rd_word;
    logic [PL_W-1:0]   w_head;

    assign w_in_range = ({1'b0, req_addr} < (ADDR_W + 1)'(DEPTH));
    assign w_idx      = req_addr[IDX_W-1:0];
    assign w_wr_acc   = req_valid && req_ready && req_we;
    assign w_rd_acc   = req_valid && req_ready && !req_we;
    assign w_rd_word  = w_in_range ? r_mem[w_idx] : '0;

    // Outstanding covers pipeline plus buffer, so the buffer can never overflow.
    assign req_ready  = r_live && !w_full && (r_outstanding < CNT_W'(RESP_DEPTH));

    assign resp_valid = !w_empty;
    assign w_pop      = resp_valid && resp_ready;
    assign {resp_err, resp_rdata} = w_head;

    always_ff @(posedge clk) begin
        if (w_wr_acc && w_in_range) begin
            for (int b = 0; b < BE_W; b++) begin
                if (req_be[b]) r_mem[w_idx][b*8 +: 8] <= req_wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_live        <= 1'b0;
            r_outstanding <= '0;
            r_pv          <= '0;
            for (int s = 0; s < RD_LAT; s++) r_pd[s] <= '0;
        end else begin
            r_live  <= 1'b1;
            r_pv[0] <= w_rd_acc;
            r_pd[0] <= {~w_in_range, w_rd_word};
            for (int s = 1; s < RD_LAT; s++) begin
                r_pv[s] <= r_pv[s-1];
                r_pd[s] <= r_pd[s-1];
            end
            case ({w_rd_acc, w_pop})
                2'b10:   r_outstanding <= r_outstanding + CNT_W'(1);
                2'b01:   r_outstanding <= r_outstanding - CNT_W'(1);
                default: ;
            endcase
        end
    end

    resp_fifo #(
        .WIDTH (PL_W),
        .DEPTH (RESP_DEPTH)
    ) u_resp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (r_pv[RD_LAT-1]),
        .push_data (r_pd[RD_LAT-1]),
        .pop       (w_pop),
        .pop_data  (w_head),
        .full      (w_full),
        .empty     (w_empty)
    );

endmodule

`default_nettype wire

// File: tb/tb_data_mem_pl.sv
// ============================================================================
//  Module      : tb_data_mem_pl
//  Description : Self-checking bench for data_mem_pl (vector table + sequences).
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_data_mem_pl;

    localparam int RD_LAT     = 2;
    localparam int RESP_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [15:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic        s_req_valid = 1'b0;
    logic        s_req_we = 1'b0;
    logic [15:0] s_req_addr = '0;
    logic [31:0] s_req_wdata = '0;
    logic [3:0]  s_req_be = '0;
    logic        s_resp_ready = 1'b1;
    logic        s_req_ready [4];
    logic        s_resp_valid [4];
    logic [31:0] s_resp_rdata [4];
    logic        s_resp_err [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_pl #(
        .DATA_W     (32),
        .ADDR_W     (16),
        .DEPTH      (1024),
        .RD_LAT     (RD_LAT),
        .RESP_DEPTH (RESP_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_be     (req_be),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    // One instance per read latency; deep enough buffer to stream every cycle.
    generate
        for (genvar k = 0; k < 4; k++) begin : g_sweep
            data_mem_pl #(
                .DATA_W     (32),
                .ADDR_W     (16),
                .DEPTH      (64),
                .RD_LAT     (k + 1),
                .RESP_DEPTH (6)
            ) u_dut (
                .clk        (clk),
                .rst        (rst),
                .req_valid  (s_req_valid),
                .req_ready  (s_req_ready[k]),
                .req_we     (s_req_we),
                .req_addr   (s_req_addr),
                .req_wdata  (s_req_wdata),
                .req_be     (s_req_be),
                .resp_valid (s_resp_valid[k]),
                .resp_ready (s_resp_ready),
                .resp_rdata (s_resp_rdata[k]),
                .resp_err   (s_resp_err[k])
            );
        end
    endgenerate

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] be);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = addr;
        req_wdata = data;
        req_be    = be;
        tick();
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    task automatic do_read(input string name, input logic [15:0] addr,
                           input logic [31:0] exp_d, input logic exp_e);
        int lat;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = addr;
        req_be    = '0;
        tick();
        req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 12) begin
            tick();
            lat++;
        end
        check({name, "_lat"},   32'(lat), 32'(RD_LAT));
        check({name, "_rdata"}, resp_rdata, exp_d);
        check({name, "_err"},   32'(resp_err), 32'(exp_e));
        tick();
    endtask

    function automatic logic [31:0] sw_data(input int i);
        return 32'h5A00_0000 + 32'(i) * 32'h0001_0203;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] st_addr [5];
        logic [31:0] st_data [5];
        int          acc;
        int          got;
        int          seen;
        int          j;
        logic        rdy;
        logic        vld;
        logic [31:0] dat;
        logic        exp_v;

        // we, addr, wdata, be, expected rdata, expected err
        vecs.push_back('{1'b1, 16'd5,    32'hDEADBEEF, 4'hF, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 16'd5,    32'h0,        4'h0, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{1'b1, 16'd7,    32'hFFFFFFFF, 4'hF, 32'h0,        1'b0});
        vecs.push_back('{1'b1, 16'd7,    32'h00000000, 4'h5, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 16'd7,    32'h0,        4'h0, 32'hFF00FF00, 1'b0});
        vecs.push_back('{1'b1, 16'd9,    32'hA5A5A5A5, 4'hF, 32'h0,        1'b0});
        vecs.push_back('{1'b1, 16'd9,    32'h12345678, 4'h0, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 16'd9,    32'h0,        4'h0, 32'hA5A5A5A5, 1'b0});
        vecs.push_back('{1'b1, 16'd10,   32'h00000000, 4'hF, 32'h0,        1'b0});
        vecs.push_back('{1'b1, 16'd10,   32'h11223344, 4'h2, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 16'd10,   32'h0,        4'h0, 32'h00003300, 1'b0});
        vecs.push_back('{1'b0, 16'd2000, 32'h0,        4'h0, 32'h00000000, 1'b1});
        vecs.push_back('{1'b1, 16'd976,  32'hCAFEF00D, 4'hF, 32'h0,        1'b0});
        vecs.push_back('{1'b1, 16'd2000, 32'h00000000, 4'hF, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 16'd976,  32'h0,        4'h0, 32'hCAFEF00D, 1'b0});
        vecs.push_back('{1'b1, 16'd1023, 32'h0BADC0DE, 4'hF, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 16'd1023, 32'h0,        4'h0, 32'h0BADC0DE, 1'b0});
        vecs.push_back('{1'b0, 16'd1024, 32'h0,        4'h0, 32'h00000000, 1'b1});

        // Reset state
        tick();
        tick();
        check("rst_req_ready",  32'(req_ready),  32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata,      32'd0);
        check("rst_resp_err",   32'(resp_err),   32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_ready", 32'(req_ready), 32'd1);

        // Vector table
        foreach (vecs[i]) begin
            if (vecs[i].we) begin
                do_write(vecs[i].addr, vecs[i].wdata, vecs[i].be);
            end else begin
                do_read($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp_rdata, vecs[i].exp_err);
            end
        end
        check("idle_no_resp", 32'(resp_valid), 32'd0);

        // Backpressure: fill to RESP_DEPTH, hold, then drain with a concurrent accept
        st_addr = '{16'd5, 16'd7, 16'd9, 16'd10, 16'd976};
        st_data = '{32'hDEADBEEF, 32'hFF00FF00, 32'hA5A5A5A5, 32'h00003300, 32'hCAFEF00D};
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            req_addr = st_addr[acc];
            rdy = req_ready;
            tick();
            if (rdy) acc++;
        end
        check("stall_accepts",   32'(acc),       32'(RESP_DEPTH));
        check("stall_ready_low", 32'(req_ready), 32'd0);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("stall_hold%0d_valid", c), 32'(resp_valid), 32'd1);
            check($sformatf("stall_hold%0d_rdata", c), resp_rdata,      32'hDEADBEEF);
            check($sformatf("stall_hold%0d_err", c),   32'(resp_err),   32'd0);
            tick();
        end
        resp_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 20 && got < 5; c++) begin
            rdy = req_ready;
            vld = resp_valid;
            dat = resp_rdata;
            tick();
            if (rdy && req_valid) begin
                req_valid = 1'b0;
                acc++;
            end
            if (vld) begin
                check($sformatf("drain_resp%0d", got), dat, st_data[got]);
                got++;
            end
        end
        check("drain_count",   32'(got), 32'd5);
        check("drain_accepts", 32'(acc), 32'd5);
        check("drain_empty",   32'(resp_valid), 32'd0);

        // Reset with reads in flight
        req_valid = 1'b1;
        req_we    = 1'b0;
        for (int c = 0; c < 3; c++) begin
            req_addr = st_addr[c];
            tick();
        end
        rst = 1'b1;
        req_valid = 1'b0;
        #1;
        check("midrst_resp_valid", 32'(resp_valid), 32'd0);
        check("midrst_req_ready",  32'(req_ready),  32'd0);
        check("midrst_rdata",      resp_rdata,      32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rel_req_ready", 32'(req_ready), 32'd1);
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (resp_valid) seen++;
            tick();
        end
        check("rel_no_stale_resp", 32'(seen), 32'd0);
        do_read("rel_mem_kept", 16'd7, 32'hFF00FF00, 1'b0);

        // Latency sweep RD_LAT=1..4 with streaming reads
        s_req_valid = 1'b1;
        s_req_we    = 1'b1;
        s_req_be    = 4'hF;
        for (int i = 0; i < 8; i++) begin
            s_req_addr  = 16'(i);
            s_req_wdata = sw_data(i);
            tick();
        end
        s_req_we = 1'b0;
        for (int c = 0; c < 16; c++) begin
            if (c < 8) begin
                s_req_valid = 1'b1;
                s_req_addr  = 16'(c);
            end else begin
                s_req_valid = 1'b0;
            end
            tick();
            for (int k = 0; k < 4; k++) begin
                j = c - (k + 1);
                exp_v = (j >= 0) && (j < 8);
                check($sformatf("sweep_lat%0d_c%0d_valid", k + 1, c), 32'(s_resp_valid[k]), 32'(exp_v));
                if (exp_v) begin
                    check($sformatf("sweep_lat%0d_c%0d_rdata", k + 1, c), s_resp_rdata[k], sw_data(j));
                    check($sformatf("sweep_lat%0d_c%0d_err", k + 1, c), 32'(s_resp_err[k]), 32'd0);
                end
                if (c < 7) begin
                    check($sformatf("sweep_lat%0d_c%0d_ready", k + 1, c), 32'(s_req_ready[k]), 32'd1);
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/data_mem_pl.md
DATA_MEM_PL -- requirements
Module: data_mem_pl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, word width in bits (multiple of 8).
REQ-002 SHALL have parameter ADDR_W, default 16, word-address width.
REQ-003 SHALL have parameter DEPTH, default 65536, number of words implemented (DEPTH <= 2**ADDR_W).
REQ-004 SHALL have parameter RD_LAT, default 1, read pipeline latency in cycles (legal range 1..4).
REQ-005 SHALL have parameter RESP_DEPTH, default 4, response buffer entries (>= 2).
REQ-006 SHALL have ports: clk  in  1  single clock, all logic on posedge.
REQ-007 SHALL have ports: rst  in  1  reset, asynchronous, active-high.
REQ-008 SHALL have ports: req_valid  in  1  request present.
REQ-009 SHALL have ports: req_ready  out  1  request accepted when valid&&ready at posedge.
REQ-010 SHALL have ports: req_we  in  1  1 = write, 0 = read.
REQ-011 SHALL have ports: req_addr  in  ADDR_W  word address.
REQ-012 SHALL have ports: req_wdata  in  DATA_W  write data.
REQ-013 SHALL have ports: req_be  in  DATA_W/8  byte enables, bit i covers byte i.
REQ-014 SHALL have ports: resp_valid  out  1  read response present.
REQ-015 SHALL have ports: resp_ready  in  1  consumer takes response.
REQ-016 SHALL have ports: resp_rdata  out  DATA_W  read data.
REQ-017 SHALL have ports: resp_err  out  1  read address was out of range.

Function
REQ-018 SHALL accept a request only on a posedge where req_valid && req_ready; requests are in-order, one per cycle max.
REQ-019 SHALL commit an accepted write at that edge, updating only bytes with req_be[i]=1; req_be=0 is a legal no-op.
REQ-020 SHALL make a write accepted at edge N visible to a read accepted at edge N+1 or later.
REQ-021 SHALL sample the array for an accepted read at its accept edge and carry data through an RD_LAT-stage valid-tagged pipeline into the response buffer.
REQ-022 SHALL, with empty buffer, assert resp_valid exactly RD_LAT cycles after the accepting edge.
REQ-023 SHALL produce no response for writes.
REQ-024 SHALL treat req_addr >= DEPTH as out of range: writes dropped; reads return resp_rdata=0, resp_err=1.
REQ-025 SHALL keep resp_valid, resp_rdata, resp_err stable while resp_valid && !resp_ready.
REQ-026 SHALL track outstanding = reads in pipeline + buffer occupancy; +1 on read accept, -1 on response handshake, unchanged when both occur.
REQ-027 SHALL drive req_ready = (outstanding < RESP_DEPTH), independent of req_valid and req_we.
REQ-028 SHALL never overflow the response buffer and never drop or reorder responses.
REQ-029 SHALL allow a new read accept and a response pop in the same cycle at outstanding = RESP_DEPTH-1 and at full only once the pop has reduced outstanding.
REQ-030 SHALL wrap buffer read/write pointers modulo RESP_DEPTH.

Reset
REQ-031 SHALL, while rst=1, force req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, outstanding=0, pipeline valids=0, buffer pointers=0.
REQ-032 SHALL discard all in-flight reads on reset; no resp_valid for pre-reset requests after release.
REQ-033 SHALL NOT clear memory array contents on reset; writes in progress at reset assertion are not guaranteed.
REQ-034 SHALL assert req_ready on the first posedge after rst deasserts.

Structure
REQ-035 SHALL place default parameter values and the RD_LAT/RESP_DEPTH legal-range constants in shared package dmem_pkg.
REQ-036 SHALL implement the response buffer as sub-module resp_fifo (synchronous, parametrised width/depth, full/empty flags).
REQ-037 SHALL flag illegal parameters (RD_LAT outside 1..4, DATA_W%8!=0, DEPTH>2**ADDR_W) at elaboration.

Verification
REQ-038 Write 0xDEADBEEF addr 5 be=1111, then read addr 5 next cycle -> resp_valid RD_LAT cycles later, rdata=0xDEADBEEF, err=0.
REQ-039 Write 0xFFFFFFFF addr 7, then 0x00000000 with be=0101, read addr 7 -> rdata=0xFF00FF00.
REQ-040 resp_ready=0, issue back-to-back reads -> exactly RESP_DEPTH accepted, req_ready=0 thereafter; release resp_ready -> all RESP_DEPTH responses in order, unchanged while stalled.
REQ-041 DEPTH=1024, read addr 2000 -> rdata=0, err=1; write addr 2000 then read addr 2000&1023 -> original data unchanged.
REQ-042 Assert rst with 3 reads in flight, release -> no resp_valid, req_ready=1 one edge after release, memory contents preserved.
REQ-043 Sweep RD_LAT=1..4 with continuous reads and resp_ready=1 -> one response per cycle, latency exactly RD_LAT.
